// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: three producer result ports, their stalls, flush and the writeback bus.
// The slave modport is the arbiter's view; master is the producers'/ROB side.
interface wb_arbiter_if;
    logic        scalu_valid;
    logic        scalu_error;
    logic [4:0]  scalu_ecause;
    logic [6:0]  scalu_robid;
    logic [5:0]  scalu_rd;
    logic [31:0] scalu_result;

    logic        mcalu_valid;
    logic        mcalu_error;
    logic [4:0]  mcalu_ecause;
    logic [6:0]  mcalu_robid;
    logic [5:0]  mcalu_rd;
    logic [31:0] mcalu_result;

    logic        lsq_valid;
    logic        lsq_error;
    logic [4:0]  lsq_ecause;
    logic [6:0]  lsq_robid;
    logic [5:0]  lsq_rd;
    logic [31:0] lsq_result;

    logic        rob_flush;

    logic        wb_scalu_stall;
    logic        wb_mcalu_stall;
    logic        wb_lsq_stall;

    logic        wb_valid;
    logic        wb_error;
    logic [4:0]  wb_ecause;
    logic [6:0]  wb_robid;
    logic [5:0]  wb_rd;
    logic [31:0] wb_result;

    modport slave (
        input  scalu_valid, scalu_error, scalu_ecause, scalu_robid, scalu_rd, scalu_result,
        input  mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd, mcalu_result,
        input  lsq_valid, lsq_error, lsq_ecause, lsq_robid, lsq_rd, lsq_result,
        input  rob_flush,
        output wb_scalu_stall, wb_mcalu_stall, wb_lsq_stall,
        output wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );

    modport master (
        output scalu_valid, scalu_error, scalu_ecause, scalu_robid, scalu_rd, scalu_result,
        output mcalu_valid, mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd, mcalu_result,
        output lsq_valid, lsq_error, lsq_ecause, lsq_robid, lsq_rd, lsq_result,
        output rob_flush,
        input  wb_scalu_stall, wb_mcalu_stall, wb_lsq_stall,
        input  wb_valid, wb_error, wb_ecause, wb_robid, wb_rd, wb_result
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges scalu/mcalu/lsq results onto one writeback bus (WB_RR_EN: round-robin, else lsq > mcalu > scalu).
// Latency: one cycle from grant to wb_valid; one result per cycle.
// Backpressure: losing producers see a combinational stall and hold; the writeback bus itself is never stalled.
module wb_arbiter (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    typedef struct packed {
        logic        error;
        logic [4:0]  ecause;
        logic [6:0]  robid;
        logic [5:0]  rd;
        logic [31:0] result;
    } wb_fields_t;

    // Bit order of vld/grant matches the source index: 0 scalu, 1 mcalu, 2 lsq.
    logic [2:0] vld;
    logic [2:0] grant;
    wb_fields_t src_scalu, src_mcalu, src_lsq;
    wb_fields_t sel_f;
    wb_fields_t wb_q;
    logic       wb_valid_q;

    assign vld = {bus.lsq_valid, bus.mcalu_valid, bus.scalu_valid};

    assign src_scalu = {bus.scalu_error, bus.scalu_ecause, bus.scalu_robid, bus.scalu_rd, bus.scalu_result};
    assign src_mcalu = {bus.mcalu_error, bus.mcalu_ecause, bus.mcalu_robid, bus.mcalu_rd, bus.mcalu_result};
    assign src_lsq   = {bus.lsq_error, bus.lsq_ecause, bus.lsq_robid, bus.lsq_rd, bus.lsq_result};

`ifdef WB_RR_EN
    logic [1:0] last;

    // Search starts just after the last winner, wrapping through 0..2.
    always_comb begin
        grant = 3'b000;
        if (!bus.rob_flush) begin
            case (last)
                2'd0: begin
                    if (vld[1])      grant = 3'b010;
                    else if (vld[2]) grant = 3'b100;
                    else if (vld[0]) grant = 3'b001;
                end
                2'd1: begin
                    if (vld[2])      grant = 3'b100;
                    else if (vld[0]) grant = 3'b001;
                    else if (vld[1]) grant = 3'b010;
                end
                default: begin
                    if (vld[0])      grant = 3'b001;
                    else if (vld[1]) grant = 3'b010;
                    else if (vld[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 2'd2;
        end else if (grant[0]) begin
            last <= 2'd0;
        end else if (grant[1]) begin
            last <= 2'd1;
        end else if (grant[2]) begin
            last <= 2'd2;
        end
    end
`else
    always_comb begin
        grant = 3'b000;
        if (!bus.rob_flush) begin
            if (vld[2])      grant = 3'b100;
            else if (vld[1]) grant = 3'b010;
            else if (vld[0]) grant = 3'b001;
        end
    end
`endif

    assign bus.wb_scalu_stall = vld[0] & ~grant[0];
    assign bus.wb_mcalu_stall = vld[1] & ~grant[1];
    assign bus.wb_lsq_stall   = vld[2] & ~grant[2];

    always_comb begin
        sel_f = src_scalu;
        if (grant[1]) sel_f = src_mcalu;
        if (grant[2]) sel_f = src_lsq;
    end

    // Fields only load on a grant so idle cycles keep the last written-back values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= |grant;
            if (|grant) begin
                wb_q <= sel_f;
            end
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_error  = wb_q.error;
    assign bus.wb_ecause = wb_q.ecause;
    assign bus.wb_robid  = wb_q.robid;
    assign bus.wb_rd     = wb_q.rd;
    assign bus.wb_result = wb_q.result;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random contention against a queue-free arbitration model.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
    wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic        s_valid [3];
    logic        s_err   [3];
    logic [4:0]  s_ec    [3];
    logic [6:0]  s_robid [3];
    logic [5:0]  s_rd    [3];
    logic [31:0] s_res   [3];

    int          m_last = 2;
    logic        e_valid = 1'b0;
    logic [50:0] e_f = '0;
    int          last_g = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [50:0] fields(input int i);
        return {s_err[i], s_ec[i], s_robid[i], s_rd[i], s_res[i]};
    endfunction

    // Winner index for the current inputs, or -1 when nothing is granted.
    function automatic int pick();
        if (flush) return -1;
`ifdef WB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (s_valid[(m_last + k) % 3]) return (m_last + k) % 3;
        end
`else
        for (int i = 2; i >= 0; i--) begin
            if (s_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_src(input int i, input logic v, input logic er, input logic [4:0] ec,
                           input logic [6:0] rb, input logic [5:0] rd, input logic [31:0] res);
        s_valid[i] = v; s_err[i] = er; s_ec[i] = ec; s_robid[i] = rb; s_rd[i] = rd; s_res[i] = res;
    endtask

    task automatic apply();
        bus.scalu_valid = s_valid[0]; bus.scalu_error = s_err[0]; bus.scalu_ecause = s_ec[0];
        bus.scalu_robid = s_robid[0]; bus.scalu_rd = s_rd[0]; bus.scalu_result = s_res[0];
        bus.mcalu_valid = s_valid[1]; bus.mcalu_error = s_err[1]; bus.mcalu_ecause = s_ec[1];
        bus.mcalu_robid = s_robid[1]; bus.mcalu_rd = s_rd[1]; bus.mcalu_result = s_res[1];
        bus.lsq_valid = s_valid[2]; bus.lsq_error = s_err[2]; bus.lsq_ecause = s_ec[2];
        bus.lsq_robid = s_robid[2]; bus.lsq_rd = s_rd[2]; bus.lsq_result = s_res[2];
        bus.rob_flush = flush;
    endtask

    // Entered just after a negedge; returns at the following negedge with outputs checked.
    task automatic step();
        int g;
        logic [2:0] vv;
        logic [2:0] exp_st;
        apply();
        #1;
        g = pick();
        vv = {s_valid[2], s_valid[1], s_valid[0]};
        exp_st = vv;
        if (g >= 0) exp_st[g] = 1'b0;
        if (!rst || vv == 3'b000)
            chk("stall", {61'b0, bus.wb_lsq_stall, bus.wb_mcalu_stall, bus.wb_scalu_stall}, {61'b0, exp_st});
        @(posedge clk);
        if (rst) begin
            e_valid = 1'b0; e_f = '0; m_last = 2; last_g = -1;
        end else begin
            e_valid = (g >= 0);
            if (g >= 0) begin
                e_f = fields(g);
                m_last = g;
            end
            last_g = g;
        end
        @(negedge clk);
        chk("wb_valid", {63'b0, bus.wb_valid}, {63'b0, e_valid});
        chk("wb_fields", {13'b0, bus.wb_error, bus.wb_ecause, bus.wb_robid, bus.wb_rd, bus.wb_result},
            {13'b0, e_f});
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) set_src(i, 1'b0, 1'b0, 5'd0, 7'd0, 6'd0, 32'd0);
    endtask

    initial begin
        logic [6:0] rr_seq [6];
        rr_seq[0] = 7'd1; rr_seq[1] = 7'd2; rr_seq[2] = 7'd3;
        rr_seq[3] = 7'd1; rr_seq[4] = 7'd2; rr_seq[5] = 7'd3;

        rst = 1'b1; flush = 1'b0; clear_all(); apply();
        @(negedge clk);
        step(); step();
        chk("reset_valid", {63'b0, bus.wb_valid}, 64'd0);
        chk("reset_result", {32'b0, bus.wb_result}, 64'd0);

        // Single scalu result: one cycle of latency, then idle.
        rst = 1'b0;
        set_src(0, 1'b1, 1'b0, 5'd0, 7'd5, 6'd3, 32'h1234);
        step();
        chk("t1_robid", {57'b0, bus.wb_robid}, 64'd5);
        chk("t1_result", {32'b0, bus.wb_result}, 64'h1234);
        clear_all();
        step();
        chk("t1_drop", {63'b0, bus.wb_valid}, 64'd0);

        // All three valid continuously from reset.
        rst = 1'b1; step(); rst = 1'b0;
        set_src(0, 1'b1, 1'b0, 5'd0, 7'd1, 6'd11, 32'hA1);
        set_src(1, 1'b1, 1'b0, 5'd0, 7'd2, 6'd12, 32'hA2);
        set_src(2, 1'b1, 1'b0, 5'd0, 7'd3, 6'd13, 32'hA3);
        for (int k = 0; k < 6; k++) begin
            step();
`ifdef WB_RR_EN
            chk("rr_order", {57'b0, bus.wb_robid}, {57'b0, rr_seq[k]});
`else
            chk("fixed_order", {57'b0, bus.wb_robid}, 64'd3);
`endif
        end

        // mcalu exception passes through.
        clear_all();
        set_src(1, 1'b1, 1'b1, 5'd13, 7'd77, 6'd9, 32'hDEAD_BEEF);
        step();
        chk("err_flag", {63'b0, bus.wb_error}, 64'd1);
        chk("err_cause", {59'b0, bus.wb_ecause}, 64'd13);
        chk("err_robid", {57'b0, bus.wb_robid}, 64'd77);

        // Flush suppresses the grant; next cycle arbitrates normally.
        clear_all();
        set_src(0, 1'b1, 1'b0, 5'd0, 7'd20, 6'd1, 32'h20);
        set_src(2, 1'b1, 1'b0, 5'd0, 7'd22, 6'd2, 32'h22);
        flush = 1'b1;
        step();
        chk("flush_valid", {63'b0, bus.wb_valid}, 64'd0);
        flush = 1'b0;
        s_valid[2] = 1'b0;
        step();
        chk("post_flush_robid", {57'b0, bus.wb_robid}, 64'd20);
        clear_all();
        step();

        // Reset while busy with two stalled sources.
        set_src(0, 1'b1, 1'b0, 5'd0, 7'd31, 6'd1, 32'h31);
        set_src(1, 1'b1, 1'b0, 5'd0, 7'd32, 6'd2, 32'h32);
        set_src(2, 1'b1, 1'b0, 5'd0, 7'd33, 6'd3, 32'h33);
        step();
        rst = 1'b1; flush = 1'b1;
        step();
        chk("rst_valid", {63'b0, bus.wb_valid}, 64'd0);
        chk("rst_robid", {57'b0, bus.wb_robid}, 64'd0);
        rst = 1'b0; flush = 1'b0;
        step();
`ifdef WB_RR_EN
        chk("rst_first", {57'b0, bus.wb_robid}, 64'd31);
`else
        chk("rst_first", {57'b0, bus.wb_robid}, 64'd33);
`endif

        // Random contention: stalled producers hold, others change freely.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(s_valid[i] && last_g != i)) begin
                    set_src(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                            5'($urandom), 7'($urandom), 6'($urandom), $urandom);
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that merges results from the scalar ALU, the multicycle ALU and the load/store queue onto the single writeback bus feeding the ROB and register file. It is the consumer end of each functional unit's valid/stall result interface. Each cycle it selects at most one valid producer, stalls the others, and registers the winner onto the writeback bus with one cycle of latency.

## Interface
- No parameters; three fixed sources, indexed 0 = scalu, 1 = mcalu, 2 = lsq.
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- scalu_valid / mcalu_valid / lsq_valid  input  1  source holds a result this cycle
- scalu_error / mcalu_error / lsq_error  input  1  result carries an exception
- scalu_ecause / mcalu_ecause / lsq_ecause  input  5  exception cause
- scalu_robid / mcalu_robid / lsq_robid  input  7  ROB entry
- scalu_rd / mcalu_rd / lsq_rd  input  6  destination register
- scalu_result / mcalu_result / lsq_result  input  32  result value
- wb_scalu_stall / wb_mcalu_stall / wb_lsq_stall  output  1  source not accepted this cycle; must hold its result
- wb_valid  output  1  writeback bus carries a result
- wb_error  output  1  registered error of the winner
- wb_ecause  output  5  registered ecause
- wb_robid  output  7  registered robid
- wb_rd  output  6  registered rd
- wb_result  output  32  registered result
- rob_flush  input  1  pipeline flush

## Operation
- Grant is combinational from the three valid inputs in the same cycle; at most one grant per cycle.
- wb_X_stall = X_valid & ~grant_X. A source with valid low never sees stall.
- A granted source's fields are captured into the output register at the clock edge; wb_valid <= |grant.
- When no source is valid: wb_valid <= 0, other output fields hold their previous values.
- Fields pass through unmodified; no width conversion, no arithmetic.
- The round-robin pointer `last` (2 bits, values 0..2) records the last granted index. Priority order is last+1, last+2, last (mod 3). It is updated only on a cycle with a grant.
- rob_flush: no grant this cycle; wb_valid <= 0; `last` unchanged; stall outputs still equal the valid inputs (producers flush themselves, so the value is don't-care).
- rst has priority over rob_flush. All outputs and `last` are reset.

## Timing
- Latency: a result granted in cycle N appears on wb_* in cycle N+1, valid for exactly one cycle.
- Throughput: one result per cycle. There is no downstream backpressure; the ROB and regfile always accept.
- A stalled producer keeps valid high with stable fields until granted. Under round-robin, any continuously valid source is granted within 3 cycles.
- Reset values: wb_valid=0, wb_error=0, wb_ecause=0, wb_robid=0, wb_rd=0, wb_result=0, last=2 (so scalu has first priority).
- Stall outputs are combinational and are 0 while all valids are 0, including during reset.
- A flush in cycle N gives wb_valid=0 in N+1. A valid input in N+1 is arbitrated normally.

## Configuration
- WB_RR_EN defined: round-robin arbitration as described above.
- WB_RR_EN undefined: fixed priority lsq > mcalu > scalu. `last` is not implemented. Starvation of lower-priority sources is permitted.

## Test plan
- Reset, then scalu_valid=1, robid=5, rd=3, result=0x1234 for one cycle -> no stall; next cycle wb_valid=1, wb_robid=5, wb_rd=3, wb_result=0x1234; the cycle after, wb_valid=0.
- All three sources valid continuously from reset with distinct robids 1/2/3 (WB_RR_EN) -> grants in order scalu, mcalu, lsq, scalu; each stalled source holds; each wb_robid appears exactly once per 3 cycles.
- Same stimulus without WB_RR_EN -> lsq robid 3 on every cycle; wb_scalu_stall=1 and wb_mcalu_stall=1 throughout.
- mcalu_valid=1, error=1, ecause=13 -> next cycle wb_error=1, wb_ecause=13, wb_robid matches.
- lsq and scalu valid together with rob_flush=1 -> next cycle wb_valid=0 and `last` unchanged. Flush deasserted with scalu alone valid -> scalu granted, wb_valid=1 the following cycle.
- rst asserted while wb_valid=1 and two sources are stalled -> next cycle all wb_* outputs are 0. After release with all valid, scalu is granted first.
